// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with relative/register branches,
// branch-and-link and a circular return-address stack (RAS).
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   rst_n        in   synchronous active-low reset
//   stall        in   freeze all state (link_we forced low)
//   op[2:0]      in   SEQ=0 BR=1 BL=2 RET=3 BX=4, 5..7 behave as SEQ
//   cond_pass    in   condition result; low turns any op into SEQ
//   br_offset    in   signed word offset for BR/BL
//   reg_target   in   register target for BX and RET-on-empty fallback
//   pc           out  current program counter (registered)
//   link_addr    out  return address for r14 (registered)
//   link_we      out  one-cycle strobe qualifying link_addr
//   ras_empty    out  RAS count is zero
//   ras_full     out  RAS count equals RAS_DEPTH
//   ras_overflow out  sticky: a push displaced the oldest entry
module pc_sequencer #(
    parameter int unsigned      PC_W      = 32,
    parameter int unsigned      OFF_W     = 24,
    parameter int unsigned      RAS_DEPTH = 4,
    parameter logic [PC_W-1:0]  RESET_VEC = '0,
    parameter int unsigned      PC_AHEAD  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic             cond_pass,
    input  logic [OFF_W-1:0] br_offset,
    input  logic [PC_W-1:0]  reg_target,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  link_addr,
    output logic             link_we,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        OP_SEQ = 3'd0,
        OP_BR  = 3'd1,
        OP_BL  = 3'd2,
        OP_RET = 3'd3,
        OP_BX  = 3'd4
    } op_e;

    // RAS is a circular buffer; wr_ptr is the next slot to write, so the
    // top entry lives at wr_ptr-1. When full, the slot at wr_ptr holds the
    // oldest entry, so a plain push overwrites it.
    logic [PC_W-1:0]  ras [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;

    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  rel_target;
    logic [PC_W-1:0]  reg_aligned;
    logic [PC_W-1:0]  next_pc;
    logic             push;
    logic             pop;

    assign ras_empty = (count == '0);
    assign ras_full  = (count == CNT_W'(RAS_DEPTH));
    assign top_ptr   = wr_ptr - PTR_W'(1);

    always_comb begin
        pc_inc      = pc + PC_W'(4);
        off_ext     = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
        rel_target  = pc + (off_ext << 2) + PC_W'(PC_AHEAD);
        reg_aligned = {reg_target[PC_W-1:2], 2'b00};

        next_pc = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        if (cond_pass) begin
            case (op)
                OP_BR: next_pc = rel_target;
                OP_BL: begin
                    next_pc = rel_target;
                    push    = 1'b1;
                end
                OP_RET: begin
                    if (ras_empty) begin
                        next_pc = reg_aligned;
                    end else begin
                        next_pc = ras[top_ptr];
                        pop     = 1'b1;
                    end
                end
                OP_BX:   next_pc = reg_aligned;
                default: next_pc = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= RESET_VEC;
            link_addr    <= '0;
            link_we      <= 1'b0;
            count        <= '0;
            wr_ptr       <= '0;
            ras_overflow <= 1'b0;
        end else if (stall) begin
            link_we <= 1'b0;
        end else begin
            pc      <= next_pc;
            link_we <= push;
            if (push) begin
                link_addr <= pc_inc;
                wr_ptr    <= wr_ptr + PTR_W'(1);
                if (ras_full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else if (pop) begin
                wr_ptr <= top_ptr;
                count  <= count - CNT_W'(1);
            end
        end
    end

    // Stack storage carries no reset; contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (rst_n && !stall && push) begin
            ras[wr_ptr] <= pc_inc;
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, PC and address width in bits.
REQ-002 The block SHALL have parameter OFF_W, default 24, branch word-offset width.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, at least 2).
REQ-004 The block SHALL have parameter RESET_VEC, default 0, PC value after reset.
REQ-005 The block SHALL have parameter PC_AHEAD, default 8, pipeline offset added to relative branch targets.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-008 The block SHALL have port stall, input, 1 bit, freezing all state when high.
REQ-009 The block SHALL have port op, input, 3 bits, selecting SEQ=0, BR=1, BL=2, RET=3, BX=4; values 5-7 SHALL be treated as SEQ.
REQ-010 The block SHALL have port cond_pass, input, 1 bit, giving the condition-code result; high means the op is taken.
REQ-011 The block SHALL have port br_offset, input, OFF_W bits, a signed word offset for BR and BL.
REQ-012 The block SHALL have port reg_target, input, PC_W bits, the register target for BX and the RET fallback.
REQ-013 The block SHALL have port pc, output, PC_W bits, the current program counter (registered).
REQ-014 The block SHALL have port link_addr, output, PC_W bits, the return address to write to r14 (registered).
REQ-015 The block SHALL have port link_we, output, 1 bit, a one-cycle strobe qualifying link_addr.
REQ-016 The block SHALL have ports ras_empty and ras_full, outputs, 1 bit each, giving RAS occupancy flags derived combinationally from the count.
REQ-017 The block SHALL have port ras_overflow, output, 1 bit, a sticky flag set when a push displaces an entry.

Function
REQ-018 When stall=0, the block SHALL load pc with the next value each cycle; when stall=1, pc, RAS, count and link_addr SHALL hold, link_we SHALL be 0, and op SHALL be ignored.
REQ-019 For SEQ, or any op with cond_pass=0, next pc SHALL be pc+4, with no RAS change and link_we=0.
REQ-020 The relative target SHALL be pc + (sign-extended br_offset shifted left 2) + PC_AHEAD, computed modulo 2^PC_W.
REQ-021 For BR taken, next pc SHALL be the relative target.
REQ-022 For BL taken, next pc SHALL be the relative target, link_addr SHALL become pc+4, link_we SHALL be 1 in the following cycle only, and pc+4 SHALL be pushed onto the RAS.
REQ-023 For RET taken with the RAS non-empty, next pc SHALL be the top entry and the RAS SHALL be popped; with the RAS empty, next pc SHALL be reg_target with bits [1:0] cleared and the RAS unchanged.
REQ-024 For BX taken, next pc SHALL be reg_target with bits [1:0] cleared.
REQ-025 A BL push when the RAS is full SHALL overwrite the oldest entry (circular), keep the count at RAS_DEPTH, and set ras_overflow.
REQ-026 ras_overflow SHALL clear only on reset.
REQ-027 pc+4 SHALL wrap modulo 2^PC_W with no flag.
REQ-028 Latency SHALL be one cycle from op sample to new pc; there SHALL be no combinational path from inputs to pc, link_addr or link_we.

Reset
REQ-029 When rst_n=0 at a rising edge, the block SHALL set pc=RESET_VEC, link_addr=0, link_we=0, RAS count=0 (ras_empty=1, ras_full=0) and ras_overflow=0.
REQ-030 Reset SHALL take priority over stall and op, including mid-sequence; RAS contents are don't-care after reset.

Verification
REQ-031 The bench SHALL cover: reset then SEQ for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; pc=0xFFFFFFFC with SEQ -> pc 0x0.
REQ-032 The bench SHALL cover: pc=0x100, BR, br_offset=0x000010, cond_pass=1 -> pc 0x148; pc=0x200, br_offset=0xFFFFFE -> pc 0x200; cond_pass=0 -> pc+4.
REQ-033 The bench SHALL cover: pc=0x40, BL, br_offset=0x000004 -> pc 0x58, with link_addr 0x44 and link_we=1 for exactly one cycle; then RET -> pc 0x44, ras_empty=1.
REQ-034 The bench SHALL cover: RAS_DEPTH=4, five taken BLs -> ras_full=1, ras_overflow=1; four RETs -> return addresses of BLs 5,4,3,2 in order; a fifth RET with reg_target=0x1003 -> pc 0x1000.
REQ-035 The bench SHALL cover: stall=1 with op=BL, cond_pass=1 -> pc, RAS and count unchanged, link_we=0.
REQ-036 The bench SHALL cover: rst_n=0 asserted with stall=1 after three pushes -> next edge pc=RESET_VEC, ras_empty=1, ras_overflow=0, link_we=0.
